// File: rtl/AHB_package.sv
// -----------------------------------------------------------------------------
// AHB_package
// Shared AHB types for the interconnect: the HBURST encoding, the master
// request-controller FSM states, and the burst-type to beat-count mapping
// used by both the request controller and the arbiter monitor.
// -----------------------------------------------------------------------------
package AHB_package;

  // Standard AHB HBURST encoding.
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } req_state_e;

  // Number of beats for a burst type. An undefined-length INCR is treated
  // as a single beat; the master re-requests for each further beat.
  function automatic logic [4:0] burst_beats(input hburst_type burst);
    logic [4:0] beats;
    case (burst)
      WRAP4, INCR4:   beats = 5'd4;
      WRAP8, INCR8:   beats = 5'd8;
      WRAP16, INCR16: beats = 5'd16;
      default:        beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_burst_beat_counter.sv
// -----------------------------------------------------------------------------
// ahb_burst_beat_counter
// Counts accepted beats of one burst and flags the final beat.
//
// Ports:
//   hclk        in   clock, rising edge
//   hreset_n    in   synchronous active-low reset
//   load_i      in   start of a transaction: clear count, load limit
//   burst_i     in   burst type sampled with load_i
//   inc_i       in   a beat is accepted this cycle
//   last_beat_o out  inc_i on the final beat (count == limit)
// -----------------------------------------------------------------------------
module ahb_burst_beat_counter
  import AHB_package::*;
(
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       load_i,
  input  hburst_type burst_i,
  input  logic       inc_i,
  output logic       last_beat_o
);

  logic [3:0] count_q;
  logic [3:0] limit_q;

  // limit is beats-1, so a 16-beat burst ends at 15 and the 4-bit count
  // never has to wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      count_q <= '0;
      limit_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
      limit_q <= 4'(burst_beats(burst_i) - 5'd1);
    end else if (inc_i) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign last_beat_o = inc_i & (count_q == limit_q);

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// -----------------------------------------------------------------------------
// ahb_master_req_ctrl
// Master-side request controller: accepts one command at a time, holds a
// one-hot request toward the target slave's arbiter, counts granted beats
// and releases the request after the final beat.
//
// Optional feature: define DYNAMIC_PRIORITY_EN to add cmd_prior/hprior,
// which carry a per-command priority alongside the request.
//
// Ports:
//   hclk, hreset_n  clock, synchronous active-low reset
//   cmd_valid/ready command handshake from the master core
//   cmd_slave       target slave index (>= SLAVE_NUM flags err, no request)
//   cmd_burst       burst type of the command
//   cmd_prior       command priority        (DYNAMIC_PRIORITY_EN only)
//   hreq            registered one-hot request to the slave arbiters
//   hprior          priority sent with hreq (DYNAMIC_PRIORITY_EN only)
//   hgrant          per-slave beat grant, already qualified by ~hwait
//   beat_en         current beat accepted
//   last_beat       accepted beat is the final one
//   busy            transaction in flight
//   err             one-cycle pulse after an invalid-index command
// -----------------------------------------------------------------------------
module ahb_master_req_ctrl
  import AHB_package::*;
#(
  parameter int SLAVE_NUM   = 2,
  parameter int SLAVE_SEL_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
  parameter int PRIOR_BIT   = 1
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SLAVE_SEL_W-1:0] cmd_slave,
  input  hburst_type             cmd_burst,
`ifdef DYNAMIC_PRIORITY_EN
  input  logic [PRIOR_BIT-1:0]   cmd_prior,
  output logic [PRIOR_BIT-1:0]   hprior,
`endif
  output logic [SLAVE_NUM-1:0]   hreq,
  input  logic [SLAVE_NUM-1:0]   hgrant,
  output logic                   beat_en,
  output logic                   last_beat,
  output logic                   busy,
  output logic                   err
);

  req_state_e             state_q, state_d;
  logic [SLAVE_SEL_W-1:0] slave_q, slave_d;
  logic [SLAVE_NUM-1:0]   hreq_q, hreq_d;
  logic                   err_q, err_d;
  logic                   load;
  logic                   slave_ok;

  // Indices above SLAVE_NUM-1 are representable when SLAVE_NUM is not a
  // power of two; those commands are consumed without a request.
  assign slave_ok = (32'(cmd_slave) < 32'(SLAVE_NUM));

  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    slave_d = slave_q;
    hreq_d  = hreq_q;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (slave_ok) begin
            state_d           = ACTIVE;
            slave_d           = cmd_slave;
            hreq_d            = '0;
            hreq_d[cmd_slave] = 1'b1;
            load              = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (last_beat) begin
          state_d = IDLE;
          hreq_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hreq_d  = '0;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q <= IDLE;
      slave_q <= '0;
      hreq_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slave_q <= slave_d;
      hreq_q  <= hreq_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == ACTIVE);
  assign hreq      = hreq_q;
  assign err       = err_q;
  // Grants on other slaves, or any grant while idle, are ignored.
  assign beat_en   = busy & hgrant[slave_q];

  ahb_burst_beat_counter u_beat_cnt (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .load_i     (load),
    .burst_i    (cmd_burst),
    .inc_i      (beat_en),
    .last_beat_o(last_beat)
  );

`ifdef DYNAMIC_PRIORITY_EN
  logic [PRIOR_BIT-1:0] hprior_q;

  // Priority follows the request: loaded with it, cleared when it drops.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      hprior_q <= '0;
    end else if (load) begin
      hprior_q <= cmd_prior;
    end else if (last_beat) begin
      hprior_q <= '0;
    end
  end

  assign hprior = hprior_q;
`endif

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
module tb_ahb_master_req_ctrl;
  import AHB_package::*;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_slave;
  hburst_type cmd_burst;
  logic [2:0] hreq;
  logic [2:0] hgrant;
  logic       beat_en;
  logic       last_beat;
  logic       busy;
  logic       err;
`ifdef DYNAMIC_PRIORITY_EN
  logic       cmd_prior;
  logic       hprior;
`endif

  always #5 hclk = ~hclk;

  ahb_master_req_ctrl #(.SLAVE_NUM(3), .SLAVE_SEL_W(2), .PRIOR_BIT(1)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_slave(cmd_slave),
    .cmd_burst(cmd_burst),
`ifdef DYNAMIC_PRIORITY_EN
    .cmd_prior(cmd_prior),
    .hprior   (hprior),
`endif
    .hreq     (hreq),
    .hgrant   (hgrant),
    .beat_en  (beat_en),
    .last_beat(last_beat),
    .busy     (busy),
    .err      (err)
  );

  // Transaction-level reference model.
  int   beat_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};
  bit   m_active;
  bit   m_err;
  int   m_slave;
  int   m_total;
  int   m_done;
  logic m_prior;

  int n_checks   = 0;
  int n_pass     = 0;
  int beat_seen  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input int b,
                       input logic [2:0] g, input logic p);
    cmd_valid = v;
    cmd_slave = s;
    cmd_burst = hburst_type'(b[2:0]);
    hgrant    = g;
`ifdef DYNAMIC_PRIORITY_EN
    cmd_prior = p;
`else
    if (p) ; // priority input absent in this build
`endif
  endtask

  // Checks outputs mid-cycle, then advances the model across the edge.
  task automatic cycle();
    logic [2:0] exp_hreq;
    logic       exp_beat;
    logic       exp_last;
    #4;
    exp_hreq = m_active ? 3'(1 << m_slave) : 3'b000;
    exp_beat = m_active && hgrant[m_slave];
    exp_last = exp_beat && (m_done == m_total - 1);
    check("cmd_ready", 32'(cmd_ready), 32'(!m_active));
    check("busy",      32'(busy),      32'(m_active));
    check("hreq",      32'(hreq),      32'(exp_hreq));
    check("beat_en",   32'(beat_en),   32'(exp_beat));
    check("last_beat", 32'(last_beat), 32'(exp_last));
    check("err",       32'(err),       32'(m_err));
`ifdef DYNAMIC_PRIORITY_EN
    check("hprior",    32'(hprior),    32'(m_active ? m_prior : 1'b0));
`endif
    if (beat_en === 1'b1) beat_seen++;
    @(posedge hclk);
    if (!hreset_n) begin
      m_active = 0; m_err = 0; m_done = 0; m_prior = 1'b0;
    end else if (m_active) begin
      m_err = 0;
      if (hgrant[m_slave]) begin
        m_done++;
        if (m_done == m_total) m_active = 0;
      end
    end else begin
      m_err = 0;
      if (cmd_valid) begin
        if (cmd_slave < 3) begin
          m_active = 1;
          m_slave  = int'(cmd_slave);
          m_total  = beat_tab[int'(cmd_burst)];
          m_done   = 0;
`ifdef DYNAMIC_PRIORITY_EN
          m_prior  = cmd_prior;
`endif
        end else begin
          m_err = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    m_active = 0; m_err = 0; m_slave = 0; m_total = 1; m_done = 0; m_prior = 1'b0;
    hreset_n = 1'b0;
    drive(0, 0, 0, 3'b000, 0);
    @(posedge hclk);
    #1;
    cycle();                       // reset values
    hreset_n = 1'b1;
    cycle();

    // SINGLE to slave 1, grant at N+2.
    drive(1, 1, SINGLE, 3'b000, 1);
    cycle();
    drive(0, 0, SINGLE, 3'b000, 0);
    cycle();
    drive(0, 0, SINGLE, 3'b010, 0);
    cycle();
    drive(0, 0, SINGLE, 3'b000, 0);
    cycle();

    // INCR4 to slave 0, grant every other cycle, stray grants elsewhere.
    drive(1, 0, INCR4, 3'b000, 1);
    cycle();
    beat_seen = 0;
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, INCR4, (i % 2 == 1) ? 3'b001 : 3'b110, 0);
      cycle();
    end
    check("incr4_beats", 32'(beat_seen), 32'd4);

    // INCR16 to slave 2 with the next command already waiting.
    beat_seen = 0;
    drive(1, 2, INCR16, 3'b100, 0);
    cycle();
    for (int i = 0; i < 18; i++) begin
      drive(1, 2, SINGLE, 3'b100, 1);
      cycle();
    end
    drive(0, 0, SINGLE, 3'b000, 0);
    cycle();
    check("incr16_b2b_beats", 32'(beat_seen), 32'd17);

    // Invalid slave index.
    drive(1, 3, INCR, 3'b111, 1);
    cycle();
    drive(0, 0, SINGLE, 3'b111, 0);
    cycle();
    cycle();

    // WRAP8, reset after beat 3, then stray grants.
    drive(1, 1, WRAP8, 3'b000, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, WRAP8, 3'b010, 0);
      cycle();
    end
    hreset_n = 1'b0;
    cycle();
    hreset_n = 1'b1;
    cycle();
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      hreset_n = ($urandom_range(0, 59) != 0);
      drive(logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            logic'($urandom_range(0, 1)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_master_req_ctrl.md
# ahb_master_req_ctrl

Master-side request controller for the AHB interconnect; the initiator-side counterpart of the per-slave arbiters. It accepts one transaction command at a time from a master core, raises the one-hot `hreq` toward the target slave's arbiter, and holds the request while the arbiter returns per-beat `hgrant`. It counts accepted beats against the burst length and releases the request after the final beat. One instance sits on each master port.

## Interface
Parameters:
- `SLAVE_NUM`, 2: number of slave arbiters reachable from this master.
- `SLAVE_SEL_W`, `$clog2(SLAVE_NUM)` (minimum 1): width of the target-slave index.
- `PRIOR_BIT`, 1: width of the dynamic priority value.

Ports:
- `hclk`  in  1: clock; all logic on the rising edge.
- `hreset_n`  in  1: reset; synchronous, active-low.
- `cmd_valid`  in  1: core presents a command.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_slave`  in  SLAVE_SEL_W: target slave index.
- `cmd_burst`  in  hburst_type: burst type of the command.
- `cmd_prior`  in  PRIOR_BIT: priority of the command. Present only with `DYNAMIC_PRIORITY_EN`.
- `hreq`  out  SLAVE_NUM: one-hot request to the slave arbiters.
- `hprior`  out  PRIOR_BIT: priority sent with the request. Present only with `DYNAMIC_PRIORITY_EN`.
- `hgrant`  in  SLAVE_NUM: per-slave beat grant, already qualified by the slave's `~hwait`.
- `beat_en`  out  1: the current beat is accepted.
- `last_beat`  out  1: the accepted beat is the final beat.
- `busy`  out  1: a transaction is in flight.
- `err`  out  1: single-cycle pulse when a command with an invalid slave index is accepted.

## Operation
- The FSM has two states:
  - `IDLE`: `cmd_ready` = 1.
  - `ACTIVE`: the request is held.
- `IDLE` → `ACTIVE` on `cmd_valid` with a valid `cmd_slave` (less than `SLAVE_NUM`). On that edge the controller:
  - latches the slave index, burst type and priority;
  - clears the 4-bit beat counter;
  - loads `limit` = `burst_beats(cmd_burst)` − 1.
- Beat counts by burst type:
  - SINGLE: 1
  - INCR: 1
  - WRAP4/INCR4: 4
  - WRAP8/INCR8: 8
  - WRAP16/INCR16: 16
- Invalid index (`cmd_slave` ≥ `SLAVE_NUM`): the command is consumed, `err` pulses next cycle, and the controller stays in `IDLE`. No request is raised.
- `hreq` is a registered output, equal to one-hot(latched slave) while the state is `ACTIVE`, and 0 otherwise.
- `beat_en` = `ACTIVE` & `hgrant[latched slave]` (combinational).
- `last_beat` = `beat_en` & (count == `limit`).
- On `beat_en`:
  - count increments (4-bit; it never wraps because it exits at `limit` ≤ 15);
  - if `last_beat`, the next state is `IDLE`.
- While `hgrant[latched slave]` = 0 (arbiter busy or slave waiting), count holds and `hreq` stays high. There is no timeout.
- Grants on non-target slaves are ignored, as are any grants in `IDLE`.
- `busy` = `ACTIVE`.
- Reset values: `hreq` = 0, `hprior` = 0, `beat_en` = 0, `last_beat` = 0, `busy` = 0, `err` = 0, `cmd_ready` = 1 (state `IDLE`, count 0).
- Reset asserted mid-burst: on the next edge the state returns to `IDLE` and `hreq` drops to 0. Partial bursts are not resumed.

## Timing
- Cycle N: `cmd_valid` & `cmd_ready`. Cycle N+1: `hreq` high and `cmd_ready` low.
- The arbiter registers its grant, so the earliest `hgrant` (and therefore the earliest `beat_en`) is at N+2.
- The final beat is at cycle M (`last_beat` = 1). At M+1, `hreq` = 0 and `cmd_ready` = 1. The earliest next command is accepted at M+1, so its `hreq` is high at M+2 and the request drops for at least one cycle.
- Single-beat transaction: the minimum occupancy is 2 cycles of `hreq` (N+1..N+2).

## Configuration
- `DYNAMIC_PRIORITY_EN` defined:
  - the `cmd_prior` and `hprior` ports exist;
  - `hprior` is registered from `cmd_prior` on acceptance and held through `ACTIVE`;
  - `hprior` returns to 0 in `IDLE`.
- Not defined: both ports are absent, with no priority logic. This configuration pairs with fixed-priority or round-robin arbiters.

## Structure
- `hburst_type` stays in `AHB_package`. Add the function `burst_beats(hburst_type)` to the same package, returning a 5-bit beat count; the arbiter monitor uses the same mapping.
- Sub-module `ahb_burst_beat_counter` holds the counter, `limit` load, increment and `last_beat` compare. The FSM and request register stay in the top.

## Test plan
- SINGLE to slave 1: `hreq` = 2'b10 at N+1; `hgrant` = 2'b10 at N+2 → `beat_en` = `last_beat` = 1 at N+2, `hreq` = 0 and `cmd_ready` = 1 at N+3.
- INCR4 to slave 0, grant stalled every other cycle: exactly 4 `beat_en` pulses; `last_beat` only on the 4th; `hreq` held continuously.
- INCR16 back-to-back with a second command at the cycle after `last_beat`: count reaches 15 without wrap; `hreq` low for exactly one cycle between transactions.
- `cmd_slave` = `SLAVE_NUM` (3 with `SLAVE_NUM` = 3 → index 3): `err` = 1 for one cycle, `hreq` stays 0, `cmd_ready` stays 1.
- Reset pulled low after beat 3 of WRAP8: `hreq` = 0 and `busy` = 0 on the next edge; stray `hgrant` after reset produces no `beat_en`.
- `DYNAMIC_PRIORITY_EN` build, `cmd_prior` = 1: `hprior` = 1 from N+1 until `hreq` falls, then 0.
